// File: rtl/mmio_input_responder_pkg.sv
// Shared constants for the KEY/SW memory-mapped input responder.
package mmio_input_responder_pkg;

  localparam int unsigned DBITS = 32;

  localparam logic [DBITS-1:0] ADDRKEY = 32'hFFFF0100;
  localparam logic [DBITS-1:0] ADDRSW  = 32'hFFFF0120;

  localparam int unsigned RDY_BIT = 0;
  localparam int unsigned OVR_BIT = 2;
  localparam int unsigned IE_BIT  = 4;

  // Assemble a control-register read value from its three live bits.
  function automatic logic [DBITS-1:0] ctrl_word(input logic rdy, input logic ovr,
                                                 input logic ie);
    logic [DBITS-1:0] w;
    w          = '0;
    w[RDY_BIT] = rdy;
    w[OVR_BIT] = ovr;
    w[IE_BIT]  = ie;
    return w;
  endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchronizer plus shared-counter debouncer for one group of pins.
module input_debounce #(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 100000,
  parameter int unsigned      CNTBITS         = 17,
  parameter logic [WIDTH-1:0] RSTVAL          = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] deb,
  output logic [WIDTH-1:0] cand,
  output logic             settled,
  output logic             accept_c
);

  localparam logic [CNTBITS-1:0] CNT_LAST = CNTBITS'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]   sync1_q, sync1_d;
  logic [WIDTH-1:0]   sync2_q, sync2_d;
  logic [WIDTH-1:0]   cand_q, cand_d;
  logic [WIDTH-1:0]   deb_q, deb_d;
  logic [CNTBITS-1:0] cnt_q, cnt_d;
  logic               settled_q, settled_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= RSTVAL;
      sync2_q   <= RSTVAL;
      cand_q    <= RSTVAL;
      deb_q     <= RSTVAL;
      cnt_q     <= '0;
      settled_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cand_q    <= cand_d;
      deb_q     <= deb_d;
      cnt_q     <= cnt_d;
      settled_q <= settled_d;
    end
  end

  // Counter saturates at CNT_LAST; while stable the candidate is re-accepted every cycle.
  always_comb begin
    sync1_d   = pin;
    sync2_d   = sync1_q;
    cand_d    = cand_q;
    deb_d     = deb_q;
    cnt_d     = cnt_q;
    settled_d = settled_q;
    accept_c  = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d     = cand_q;
      settled_d = 1'b1;
      accept_c  = 1'b1;
    end else begin
      cnt_d = cnt_q + CNTBITS'(1);
    end
  end

  assign deb     = deb_q;
  assign cand    = cand_q;
  assign settled = settled_q;

endmodule

// File: rtl/mmio_input_responder.sv
// Memory-mapped responder for the KEY and SW windows: status, enables, read data, irq.
module mmio_input_responder
  import mmio_input_responder_pkg::*;
#(
  parameter int unsigned KEYBITS         = 4,
  parameter int unsigned SWBITS          = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned CNTBITS         = 17
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [DBITS-1:0]   addr,
  input  logic [DBITS-1:0]   wdata,
  input  logic               we,
  input  logic               re,
  input  logic [KEYBITS-1:0] key_pin,
  input  logic [SWBITS-1:0]  sw_pin,
  output logic               hit,
  output logic [DBITS-1:0]   rdata,
  output logic               irq
);

  localparam logic [DBITS-1:0] ADDR_KCTRL = ADDRKEY + DBITS'(4);
  localparam logic [DBITS-1:0] ADDR_SCTRL = ADDRSW + DBITS'(4);

  logic [KEYBITS-1:0] key_deb, key_cand;
  logic               key_settled, key_acc_c;
  logic [SWBITS-1:0]  sw_deb, sw_cand;
  logic               sw_settled, sw_acc_c;

  input_debounce #(
    .WIDTH(KEYBITS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNTBITS(CNTBITS),
    .RSTVAL({KEYBITS{1'b1}})
  ) u_key_deb (
    .clk(clk), .reset_n(reset_n), .pin(key_pin), .deb(key_deb), .cand(key_cand),
    .settled(key_settled), .accept_c(key_acc_c)
  );

  input_debounce #(
    .WIDTH(SWBITS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNTBITS(CNTBITS),
    .RSTVAL({SWBITS{1'b0}})
  ) u_sw_deb (
    .clk(clk), .reset_n(reset_n), .pin(sw_pin), .deb(sw_deb), .cand(sw_cand),
    .settled(sw_settled), .accept_c(sw_acc_c)
  );

  logic krdy_q, krdy_d, kovr_q, kovr_d, kie_q, kie_d;
  logic srdy_q, srdy_d, sovr_q, sovr_d, sie_q, sie_d;
  logic [DBITS-1:0] rdata_q, rdata_d;
  logic irq_q, irq_d;

  logic sel_kdata_c, sel_kctrl_c, sel_sdata_c, sel_sctrl_c;
  logic key_evt_c, sw_evt_c;
  logic rd_kdata_c, rd_sdata_c, wr_kctrl_c, wr_sctrl_c;
  logic unused_wdata;

  assign unused_wdata = ^{wdata[DBITS-1:IE_BIT+1], wdata[OVR_BIT+1], wdata[RDY_BIT+1:RDY_BIT]};

  assign sel_kdata_c = (addr == ADDRKEY);
  assign sel_kctrl_c = (addr == ADDR_KCTRL);
  assign sel_sdata_c = (addr == ADDRSW);
  assign sel_sctrl_c = (addr == ADDR_SCTRL);
  assign hit         = sel_kdata_c | sel_kctrl_c | sel_sdata_c | sel_sctrl_c;

  // Events are suppressed until the group has settled once after reset.
  assign key_evt_c = key_acc_c & key_settled & (|(key_deb & ~key_cand));
  assign sw_evt_c  = sw_acc_c & sw_settled & (|(sw_deb ^ sw_cand));

  assign rd_kdata_c = re & sel_kdata_c;
  assign rd_sdata_c = re & sel_sdata_c;
  assign wr_kctrl_c = we & sel_kctrl_c;
  assign wr_sctrl_c = we & sel_sctrl_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      krdy_q  <= 1'b0;
      kovr_q  <= 1'b0;
      kie_q   <= 1'b0;
      srdy_q  <= 1'b0;
      sovr_q  <= 1'b0;
      sie_q   <= 1'b0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      krdy_q  <= krdy_d;
      kovr_q  <= kovr_d;
      kie_q   <= kie_d;
      srdy_q  <= srdy_d;
      sovr_q  <= sovr_d;
      sie_q   <= sie_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  // A new event beats both the read-clear of RDY and the write-clear of OVR.
  always_comb begin
    krdy_d = krdy_q;
    kovr_d = kovr_q;
    kie_d  = kie_q;
    srdy_d = srdy_q;
    sovr_d = sovr_q;
    sie_d  = sie_q;

    if (rd_kdata_c) krdy_d = 1'b0;
    if (key_evt_c)  krdy_d = 1'b1;
    if (wr_kctrl_c) begin
      kie_d = wdata[IE_BIT];
      if (!wdata[OVR_BIT]) kovr_d = 1'b0;
    end
    if (key_evt_c && krdy_q && !rd_kdata_c) kovr_d = 1'b1;

    if (rd_sdata_c) srdy_d = 1'b0;
    if (sw_evt_c)   srdy_d = 1'b1;
    if (wr_sctrl_c) begin
      sie_d = wdata[IE_BIT];
      if (!wdata[OVR_BIT]) sovr_d = 1'b0;
    end
    if (sw_evt_c && srdy_q && !rd_sdata_c) sovr_d = 1'b1;
  end

  // Read data reflects register state before this edge's updates.
  always_comb begin
    rdata_d = rdata_q;
    if (re && hit) begin
      if (sel_kdata_c)      rdata_d = DBITS'(key_deb);
      else if (sel_kctrl_c) rdata_d = ctrl_word(krdy_q, kovr_q, kie_q);
      else if (sel_sdata_c) rdata_d = DBITS'(sw_deb);
      else                  rdata_d = ctrl_word(srdy_q, sovr_q, sie_q);
    end
    irq_d = (krdy_q & kie_q) | (srdy_q & sie_q);
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_mmio_input_responder.sv
// Scoreboard bench for mmio_input_responder with a short debounce window.
module tb_mmio_input_responder;

  localparam logic [31:0] A_KDATA = 32'hFFFF0100;
  localparam logic [31:0] A_KCTRL = 32'hFFFF0104;
  localparam logic [31:0] A_SDATA = 32'hFFFF0120;
  localparam logic [31:0] A_SCTRL = 32'hFFFF0124;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] addr, wdata;
  logic        we, re;
  logic [3:0]  key_pin;
  logic [9:0]  sw_pin;
  logic        hit;
  logic [31:0] rdata;
  logic        irq;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic rvalid_q = 1'b0;

  always #5 clk = ~clk;

  mmio_input_responder #(
    .KEYBITS(4), .SWBITS(10), .DEBOUNCE_CYCLES(4), .CNTBITS(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .key_pin(key_pin), .sw_pin(sw_pin), .hit(hit), .rdata(rdata), .irq(irq)
  );

  // Monitor: a mapped read captured at a rising edge is checked on the following falling edge.
  always @(posedge clk) rvalid_q <= re && hit;

  always @(negedge clk) begin
    if (rvalid_q) begin
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read rdata=%h required=none", rdata);
      end else begin
        e = sb_q.pop_front();
        if (rdata !== e.exp) begin
          failures++;
          $display("FAIL %s rdata=%h required=%h", e.name, rdata, e.exp);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    addr = a;
    re   = 1'b1;
    sb_q.push_back('{name: n, exp: e});
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    key_pin = 4'hF;
    sw_pin  = 10'h005;
    addr    = '0;
    wdata   = '0;
    we      = 1'b0;
    re      = 1'b0;
    wait_n(2);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    wait_n(7);

    // First settle after reset: values visible, no events.
    rd(A_SDATA, 32'h005, "init_sdata");
    rd(A_SCTRL, 32'h0,   "init_sctrl");
    rd(A_KDATA, 32'hF,   "init_kdata");
    rd(A_KCTRL, 32'h0,   "init_kctrl");
    addr = 32'hFFFF0108;
    #1 chk("hit_unmapped", 32'(hit), 32'h0);
    addr = A_SCTRL;
    #1 chk("hit_sctrl", 32'(hit), 32'h1);

    // Single press, then read-clear.
    @(negedge clk);
    key_pin = 4'hE;
    wait_n(7);
    rd(A_KCTRL, 32'h1, "press_kctrl");
    rd(A_KDATA, 32'hE, "press_kdata");
    rd(A_KCTRL, 32'h0, "press_kctrl_cleared");

    // Release, then bounce: nothing accepted, no event.
    key_pin = 4'hF;
    wait_n(7);
    rd(A_KDATA, 32'hF, "release_kdata");
    rd(A_KCTRL, 32'h0, "release_kctrl");
    for (int i = 0; i < 10; i++) begin
      key_pin = (i % 2 == 0) ? 4'hE : 4'hF;
      wait_n(2);
    end
    key_pin = 4'hF;
    wait_n(7);
    rd(A_KDATA, 32'hF, "bounce_kdata");
    rd(A_KCTRL, 32'h0, "bounce_kctrl");

    // Two presses without a read: overrun, then clear it.
    key_pin = 4'hE;
    wait_n(7);
    key_pin = 4'hF;
    wait_n(7);
    key_pin = 4'hE;
    wait_n(7);
    rd(A_KCTRL, 32'h5, "overrun_kctrl");
    wr(A_KCTRL, 32'h0);
    rd(A_KCTRL, 32'h1, "ovr_cleared_kctrl");
    rd(A_KDATA, 32'hE, "overrun_kdata");
    key_pin = 4'hF;
    wait_n(7);

    // Switch interrupt path.
    wr(A_SCTRL, 32'h10);
    rd(A_SCTRL, 32'h10, "sie_sctrl");
    sw_pin = 10'h105;
    wait_n(7);
    chk("irq_before", 32'(irq), 32'h0);
    @(negedge clk);
    chk("irq_raised", 32'(irq), 32'h1);
    rd(A_SDATA, 32'h105, "sw_sdata");
    chk("irq_still_high", 32'(irq), 32'h1);
    @(negedge clk);
    chk("irq_cleared", 32'(irq), 32'h0);
    rd(A_SCTRL, 32'h10, "sw_sctrl_after");
    wr(A_SCTRL, 32'h0);

    // Press coincident with a KDATA read while KRDY is already set.
    key_pin = 4'hE;
    wait_n(7);
    rd(A_KCTRL, 32'h1, "pre_coinc_kctrl");
    key_pin = 4'hF;
    wait_n(7);
    key_pin = 4'hE;
    wait_n(6);
    rd(A_KDATA, 32'hF, "coinc_kdata");
    rd(A_KCTRL, 32'h1, "coinc_kctrl");

    // Key irq, then reset in the middle of a debounce.
    wr(A_KCTRL, 32'h10);
    @(negedge clk);
    chk("key_irq", 32'(irq), 32'h1);
    rd(A_KCTRL, 32'h11, "kie_kctrl");
    key_pin = 4'hF;
    wait_n(3);
    reset_n = 1'b0;
    #1;
    chk("midreset_rdata", rdata, 32'h0);
    chk("midreset_irq", 32'(irq), 32'h0);
    wait_n(2);
    reset_n = 1'b1;
    wait_n(7);
    rd(A_KDATA, 32'hF, "post_reset_kdata");
    rd(A_KCTRL, 32'h0, "post_reset_kctrl");

    wait_n(2);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
